exec_conditioner: RTL and testbench

EXEC_CONDITIONER -- requirements
Module: exec_conditioner

---
 rtl/exec_conditioner.sv | 124 ++++++++++++
 tb/tb_exec_conditioner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_conditioner.sv
// exec_conditioner: synchronizes and debounces the raw exec push-button,
// producing a one-cycle exec strobe, a debounced level, run toggle and press count.
module exec_conditioner #(
    parameter int unsigned DEBOUNCE_LIMIT = 50000,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       exec_in,
    output logic       exec_pulse,
    output logic       exec_level,
    output logic       run,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic                 RAW_RELEASED = ACTIVE_LOW;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST     = CNT_WIDTH'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    logic                 sync_meta;
    logic                 sync_q;
    logic                 pressed;
    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 accept;

    // Reset preloads the released level so a held button looks like a fresh press.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= RAW_RELEASED;
            sync_q    <= RAW_RELEASED;
        end else begin
            sync_meta <= exec_in;
            sync_q    <= sync_meta;
        end
    end

    assign pressed = sync_q ^ ACTIVE_LOW;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            RELEASED: begin
                cnt_d = '0;
                if (pressed) begin
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Only the debounced press edge strobes; bounce returns into PRESSED do not.
    always_ff @(posedge clock) begin
        if (reset) begin
            exec_pulse  <= 1'b0;
            run         <= 1'b0;
            press_count <= '0;
        end else begin
            exec_pulse <= accept;
            if (accept) begin
                run         <= ~run;
                press_count <= press_count + 8'd1;
            end
        end
    end

    assign exec_level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: tb/tb_exec_conditioner.sv
// tb_exec_conditioner: directed and random stimulus for exec_conditioner,
// compared each cycle against a run-length debounce model.
module tb_exec_conditioner;

    localparam int LIM = 4;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       exec_in = 1'b1;
    logic       exec_pulse;
    logic       exec_level;
    logic       run;
    logic [7:0] press_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    exec_conditioner #(
        .DEBOUNCE_LIMIT(LIM),
        .CNT_WIDTH     (16),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .exec_in    (exec_in),
        .exec_pulse (exec_pulse),
        .exec_level (exec_level),
        .run        (run),
        .press_count(press_count)
    );

    // Model: the FSM sees the raw input two edges late; the level flips once
    // LIM+1 consecutive samples disagree with it.
    bit         d1 = 1'b1;
    bit         d2 = 1'b1;
    int         runlen = 0;
    bit         m_level = 1'b0;
    bit         m_pulse = 1'b0;
    bit         m_run = 1'b0;
    logic [7:0] m_cnt = 8'd0;

    always @(posedge clock) begin
        bit s;
        if (reset) begin
            d1 = 1'b1;
            d2 = 1'b1;
            runlen = 0;
            m_level = 1'b0;
            m_pulse = 1'b0;
            m_run = 1'b0;
            m_cnt = 8'd0;
        end else begin
            s = ~d2;
            d2 = d1;
            d1 = exec_in;
            m_pulse = 1'b0;
            if (s != m_level) runlen++;
            else runlen = 0;
            if (runlen == LIM + 1) begin
                m_level = s;
                runlen = 0;
                if (s) begin
                    m_pulse = 1'b1;
                    m_run = ~m_run;
                    m_cnt = m_cnt + 8'd1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("pulse", 32'(exec_pulse), 32'(m_pulse));
            check("level", 32'(exec_level), 32'(m_level));
            check("run", 32'(run), 32'(m_run));
            check("count", 32'(press_count), 32'(m_cnt));
        end
    end

    initial begin
        int p;
        int len;
        bit v;
        bit bpat [8];
        bit bnc [8];
        bpat = '{0, 0, 0, 1, 0, 0, 0, 1};
        bnc  = '{1, 1, 0, 0, 1, 1, 0, 0};

        reset = 1'b1;
        exec_in = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_pulse", 32'(exec_pulse), 0);
        check("rst_level", 32'(exec_level), 0);
        check("rst_run", 32'(run), 0);
        check("rst_count", 32'(press_count), 0);

        p = 0;
        repeat (20) begin
            @(negedge clock);
            p += int'(exec_pulse) + int'(exec_level);
        end
        check("idle_activity", 32'(p), 0);

        exec_in = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check("press_pulse", 32'(exec_pulse), 32'(k == 6));
            check("press_level", 32'(exec_level), 32'(k >= 6));
            if (k == 6) check("model_pulse", 32'(m_pulse), 1);
        end
        check("press_run", 32'(run), 1);
        check("press_count1", 32'(press_count), 1);
        exec_in = 1'b1;
        repeat (20) @(negedge clock);
        check("model_level_rel", 32'(m_level), 0);

        p = 0;
        for (int i = 0; i < 8; i++) begin
            exec_in = bpat[i];
            @(negedge clock);
            p += int'(exec_pulse) + int'(exec_level);
        end
        repeat (20) begin
            @(negedge clock);
            p += int'(exec_pulse) + int'(exec_level);
        end
        check("glitch_activity", 32'(p), 0);
        check("glitch_count", 32'(press_count), 1);

        p = 0;
        exec_in = 1'b0;
        repeat (10) begin
            @(negedge clock);
            p += int'(exec_pulse);
        end
        for (int i = 0; i < 8; i++) begin
            exec_in = bnc[i];
            @(negedge clock);
            p += int'(exec_pulse);
            check("bounce_level", 32'(exec_level), 1);
        end
        exec_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            p += int'(exec_pulse);
            check("release_level", 32'(exec_level), 32'(k < 6));
        end
        check("bounce_pulses", 32'(p), 1);
        check("bounce_count", 32'(press_count), 2);

        exec_in = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_pulse", 32'(exec_pulse), 0);
        check("mid_rst_level", 32'(exec_level), 0);
        check("mid_rst_run", 32'(run), 0);
        check("mid_rst_count", 32'(press_count), 0);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            check("held_rst_pulse", 32'(exec_pulse), 32'(k == 6));
        end
        check("held_rst_count", 32'(press_count), 1);

        exec_in = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        p = 0;
        for (int i = 0; i < 256; i++) begin
            exec_in = 1'b0;
            repeat (9) begin
                @(negedge clock);
                p += int'(exec_pulse);
            end
            exec_in = 1'b1;
            repeat (9) begin
                @(negedge clock);
                p += int'(exec_pulse);
            end
        end
        check("wrap_pulses", 32'(p), 256);
        check("wrap_count", 32'(press_count), 0);
        check("wrap_run", 32'(run), 0);

        repeat (400) begin
            v = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 10));
            exec_in = v;
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clock);
            reset = 1'b0;
            repeat (len - 1) @(negedge clock);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
